// File: rtl/mips_core_pkg.sv
// Shared types and constants for the mips_core rename stage.
// Pure declarations, no timing.
// No flow control.
package mips_core_pkg;

    localparam int PREG_W     = 6;
    localparam int FL_COUNT_W = 7;
    localparam int NUM_PREGS  = 64;
    localparam int NUM_ARCH   = 32;

    // Architectural registers start identity-mapped onto pregs 0..NUM_ARCH-1.
    localparam logic [NUM_PREGS-1:0] USED_RST  = (64'd1 << NUM_ARCH) - 64'd1;
    localparam logic [NUM_PREGS-1:0] FREE_RST  = ~USED_RST;
    localparam logic [FL_COUNT_W-1:0] COUNT_RST = FL_COUNT_W'(NUM_PREGS - NUM_ARCH);

    typedef logic [PREG_W-1:0] preg_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } fl_state_t;

    function automatic logic [FL_COUNT_W-1:0] popcount64(input logic [NUM_PREGS-1:0] v);
        logic [FL_COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            n = n + FL_COUNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/priority_encoder_32.sv
// Lowest-index priority encoder over a 32-bit request vector.
// Purely combinational, zero latency.
// No flow control; o_vld is low when no request bit is set.
module priority_encoder_32 (
    input  logic [31:0] i_req,
    output logic        o_vld,
    output logic [4:0]  o_idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = 5'(i);
            end
        end
    end

    assign o_vld = |i_req;

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical register free list: offers the lowest free preg, takes commits/releases, restores on flush.
// Offer is combinational; grant, release and commit take effect at the next edge; flush costs one RECOVER cycle.
// Rename must stall while alloc_valid is low (no queuing). Optional checker: define FREE_LIST_CHECK_EN.
module phys_reg_free_list
    import mips_core_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alloc_req,
    output logic       alloc_valid,
    output logic [5:0] alloc_preg,
    input  logic       commit_valid,
    input  logic [5:0] commit_preg,
    input  logic       release_valid,
    input  logic [5:0] release_preg,
    input  logic       flush,
    output logic [6:0] free_count,
`ifdef FREE_LIST_CHECK_EN
    output logic       err_sticky,
`endif
    output logic       empty
);

    logic [NUM_PREGS-1:0]  r_free;
    logic [NUM_PREGS-1:0]  r_used;
    fl_state_t             r_state;
    logic [FL_COUNT_W-1:0] r_count;

    logic                  w_lo_vld;
    logic                  w_hi_vld;
    logic [4:0]            w_lo_idx;
    logic [4:0]            w_hi_idx;
    preg_t                 w_alloc_preg;
    logic                  w_alloc_valid;
    logic                  w_grant;
    logic [NUM_PREGS-1:0]  w_used_next;
    logic [NUM_PREGS-1:0]  w_free_next;
    logic [FL_COUNT_W-1:0] w_count_next;

    priority_encoder_32 u_enc_lo (
        .i_req (r_free[31:0]),
        .o_vld (w_lo_vld),
        .o_idx (w_lo_idx)
    );

    priority_encoder_32 u_enc_hi (
        .i_req (r_free[63:32]),
        .o_vld (w_hi_vld),
        .o_idx (w_hi_idx)
    );

    // Low half wins whenever it has anything free; the half bit becomes the preg MSB.
    assign w_alloc_preg  = w_lo_vld ? {1'b0, w_lo_idx} : {1'b1, w_hi_idx};
    assign w_alloc_valid = (r_state == RUN) & ~flush & (w_lo_vld | w_hi_vld);
    assign w_grant       = alloc_req & w_alloc_valid;

    assign alloc_valid = w_alloc_valid;
    assign alloc_preg  = w_alloc_preg;
    assign free_count  = r_count;
    assign empty       = (r_count == '0);

    // Next-state bitmaps; flush rebuilds free from committed state including this cycle's updates.
    always_comb begin
        w_used_next = r_used;
        if (commit_valid)  w_used_next[commit_preg]  = 1'b1;
        if (release_valid) w_used_next[release_preg] = 1'b0;

        w_free_next = r_free;
        if (w_grant)       w_free_next[w_alloc_preg] = 1'b0;
        if (release_valid) w_free_next[release_preg] = 1'b1;

        w_count_next = r_count + FL_COUNT_W'(release_valid) - FL_COUNT_W'(w_grant);

        if (flush) begin
            w_free_next  = ~w_used_next;
            w_count_next = popcount64(~w_used_next);
        end
    end

    // Bitmap, count and recovery state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free  <= FREE_RST;
            r_used  <= USED_RST;
            r_state <= RUN;
            r_count <= COUNT_RST;
        end else begin
            r_free  <= w_free_next;
            r_used  <= w_used_next;
            r_state <= flush ? RECOVER : RUN;
            r_count <= w_count_next;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic r_err;
    logic w_rel_free;
    logic w_com_free;
    logic w_same_preg;
    logic w_cnt_bad;
    logic w_err_now;

    assign w_rel_free  = release_valid & r_free[release_preg];
    assign w_com_free  = commit_valid & r_free[commit_preg];
    assign w_same_preg = release_valid & commit_valid & (release_preg == commit_preg);
    assign w_cnt_bad   = (r_count != popcount64(r_free));
    assign w_err_now   = w_rel_free | w_com_free | w_same_preg | w_cnt_bad;
    assign err_sticky  = r_err;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_err_now;
        end
    end

`ifndef SYNTHESIS
    // Report illegal core behaviour as it happens.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!w_rel_free)  else $warning("free list: release of already-free preg %0d", release_preg);
            assert (!w_com_free)  else $warning("free list: commit of free preg %0d", commit_preg);
            assert (!w_same_preg) else $warning("free list: release and commit of preg %0d together", release_preg);
            assert (!w_cnt_bad)   else $warning("free list: count %0d disagrees with bitmap", r_count);
        end
    end
`endif
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: drain, release/grant overlap, flush recovery, reset aborts.
// Inputs change 1 time unit after the rising edge; outputs are compared just before the next edge.
// Optional checker exercised when FREE_LIST_CHECK_EN is defined.
module tb_phys_reg_free_list;

    logic       clk;
    logic       rst_n;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_preg;
    logic       commit_valid;
    logic [5:0] commit_preg;
    logic       release_valid;
    logic [5:0] release_preg;
    logic       flush;
    logic [6:0] free_count;
    logic       empty;
`ifdef FREE_LIST_CHECK_EN
    logic       err_sticky;
`endif

    int total = 0;
    int bad   = 0;

    phys_reg_free_list dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_req     (alloc_req),
        .alloc_valid   (alloc_valid),
        .alloc_preg    (alloc_preg),
        .commit_valid  (commit_valid),
        .commit_preg   (commit_preg),
        .release_valid (release_valid),
        .release_preg  (release_preg),
        .flush         (flush),
        .free_count    (free_count),
`ifdef FREE_LIST_CHECK_EN
        .err_sticky    (err_sticky),
`endif
        .empty         (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       req;
        logic       rv;
        logic [5:0] rp;
        logic       cv;
        logic [5:0] cp;
        logic       fl;
        logic       ev;
        logic [5:0] ep;
        logic [6:0] ec;
        logic       ee;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(input logic rst, input logic req, input logic rv, input int rp,
                                input logic cv, input int cp, input logic fl,
                                input logic ev, input int ep, input int ec, input logic ee);
        vec_t v;
        v.rst = rst; v.req = req; v.rv = rv; v.rp = 6'(rp); v.cv = cv; v.cp = 6'(cp);
        v.fl = fl; v.ev = ev; v.ep = 6'(ep); v.ec = 7'(ec); v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_req = 1'b0; commit_valid = 1'b0; commit_preg = '0;
        release_valid = 1'b0; release_preg = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        #2;

        // Table 1 starts after a full drain (no reset); table 2 entries begin with a reset.
        tbl[0]  = mk(0, 0, 1,  5, 0,  0, 0, 0,  0,  0, 1);
        tbl[1]  = mk(0, 0, 1, 40, 0,  0, 0, 1,  5,  1, 0);
        tbl[2]  = mk(0, 1, 0,  0, 0,  0, 0, 1,  5,  2, 0);
        tbl[3]  = mk(0, 1, 1,  7, 0,  0, 0, 1, 40,  1, 0);
        tbl[4]  = mk(0, 0, 0,  0, 0,  0, 0, 1,  7,  1, 0);
        tbl[5]  = mk(0, 1, 0,  0, 0,  0, 0, 1,  7,  1, 0);
        tbl[6]  = mk(0, 0, 0,  0, 0,  0, 0, 0,  0,  0, 1);
        tbl[7]  = mk(1, 1, 0,  0, 0,  0, 0, 1, 32, 32, 0);
        tbl[8]  = mk(0, 1, 0,  0, 0,  0, 0, 1, 33, 31, 0);
        tbl[9]  = mk(0, 1, 0,  0, 0,  0, 0, 1, 34, 30, 0);
        tbl[10] = mk(0, 1, 0,  0, 0,  0, 0, 1, 35, 29, 0);
        tbl[11] = mk(0, 0, 0,  0, 1, 32, 0, 1, 36, 28, 0);
        tbl[12] = mk(0, 0, 0,  0, 1, 33, 0, 1, 36, 28, 0);
        tbl[13] = mk(0, 1, 0,  0, 0,  0, 1, 0,  0, 28, 0);
        tbl[14] = mk(0, 1, 0,  0, 0,  0, 0, 0,  0, 30, 0);
        tbl[15] = mk(0, 0, 0,  0, 0,  0, 0, 1, 34, 30, 0);
        tbl[16] = mk(0, 1, 0,  0, 0,  0, 0, 1, 34, 30, 0);
        tbl[17] = mk(0, 1, 0,  0, 1, 34, 1, 0,  0, 29, 0);
        tbl[18] = mk(0, 0, 0,  0, 0,  0, 0, 0,  0, 29, 0);
        tbl[19] = mk(0, 0, 0,  0, 0,  0, 0, 1, 35, 29, 0);
        tbl[20] = mk(0, 0, 0,  0, 0,  0, 1, 0,  0, 29, 0);
        tbl[21] = mk(0, 0, 0,  0, 0,  0, 1, 0,  0, 29, 0);
        tbl[22] = mk(0, 0, 0,  0, 0,  0, 0, 0,  0, 29, 0);
        tbl[23] = mk(0, 0, 0,  0, 0,  0, 0, 1, 35, 29, 0);
        tbl[24] = mk(0, 0, 1,  3, 0,  0, 0, 1, 35, 29, 0);
        tbl[25] = mk(0, 0, 0,  0, 0,  0, 0, 1,  3, 30, 0);
        tbl[26] = mk(0, 0, 0,  0, 0,  0, 0, 1,  3, 30, 0);

        // Reset state.
        do_reset();
        chk("rst_valid", 32'(alloc_valid), 1);
        chk("rst_preg",  32'(alloc_preg),  32);
        chk("rst_count", 32'(free_count),  32);
        chk("rst_empty", 32'(empty),       0);

        // Drain: 32 back-to-back grants in ascending order.
        for (int i = 0; i < 32; i++) begin
            alloc_req = 1'b1;
            #1;
            chk("drain_valid", 32'(alloc_valid), 1);
            chk("drain_preg",  32'(alloc_preg),  32 + i);
            chk("drain_count", 32'(free_count),  32 - i);
            step();
        end
        alloc_req = 1'b1;
        #1;
        chk("drained_valid", 32'(alloc_valid), 0);
        chk("drained_empty", 32'(empty),       1);
        chk("drained_count", 32'(free_count),  0);
        step();
        alloc_req = 1'b0;
        #1;
        chk("stall_count", 32'(free_count), 0);

        // Table-driven vectors.
        for (int k = 0; k < 27; k++) begin
            if (tbl[k].rst) do_reset();
            alloc_req     = tbl[k].req;
            release_valid = tbl[k].rv;
            release_preg  = tbl[k].rp;
            commit_valid  = tbl[k].cv;
            commit_preg   = tbl[k].cp;
            flush         = tbl[k].fl;
            #1;
            chk($sformatf("v%0d_valid", k), 32'(alloc_valid), 32'(tbl[k].ev));
            if (tbl[k].ev) chk($sformatf("v%0d_preg", k), 32'(alloc_preg), 32'(tbl[k].ep));
            chk($sformatf("v%0d_count", k), 32'(free_count), 32'(tbl[k].ec));
            chk($sformatf("v%0d_empty", k), 32'(empty), 32'(tbl[k].ee));
            step();
        end
        idle_inputs();

        // Reset in the RECOVER cycle leaves no trace of the flush.
        do_reset();
        alloc_req = 1'b1;
        step();
        alloc_req = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("recover_valid", 32'(alloc_valid), 0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        chk("abort_valid", 32'(alloc_valid), 1);
        chk("abort_preg",  32'(alloc_preg),  32);
        chk("abort_count", 32'(free_count),  32);
        step();
        chk("abort_next_valid", 32'(alloc_valid), 1);

`ifdef FREE_LIST_CHECK_EN
        // Releasing an already-free preg latches the error until reset.
        do_reset();
        chk("err_rst", 32'(err_sticky), 0);
        release_valid = 1'b1;
        release_preg  = 6'd50;
        step();
        release_valid = 1'b0;
        #1;
        chk("err_set", 32'(err_sticky), 1);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("err_hold", 32'(err_sticky), 1);
        end
        do_reset();
        chk("err_clear", 32'(err_sticky), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Free-list allocator for the renaming stage of the out-of-order mips_core. It tracks 64 physical registers with two bitmaps: speculative-free and committed-in-use.
- Rename asks for one destination register per cycle, and the block grants the lowest-numbered free one.
- Commit returns stale registers to the pool.
- A flush restores the speculative free list from committed state in a one-cycle recovery.

Parameters:
- NUM_PREGS, 64, physical register count. Fixed at 64: two 32-bit encoder halves.
- NUM_ARCH, 32, architectural registers. Identity-mapped to pregs 0..NUM_ARCH-1 at reset.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- alloc_req  in  1  rename requests one destination preg this cycle
- alloc_valid  out  1  a free preg is offered. Low when empty, during RECOVER, or during flush.
- alloc_preg  out  6  offered preg, lowest free index. Meaningful only when alloc_valid=1.
- commit_valid  in  1  a destination preg becomes architectural
- commit_preg  in  6  preg being committed
- release_valid  in  1  stale preg freed at commit
- release_preg  in  6  preg being released
- flush  in  1  branch mispredict / exception squash
- free_count  out  7  number of speculatively free pregs
- empty  out  1  free_count==0

Behaviour:
- Reset (async, rst_n=0):
  - committed_used[i]=1 for i<NUM_ARCH, else 0.
  - free[i]=1 for i>=NUM_ARCH, else 0.
  - state=RUN, free_count=32, empty=0.
  - alloc_preg=32, alloc_valid=1 once rst_n deasserts.
  - Reset mid-recovery aborts recovery with no residue.
- States:
  - RUN: normal operation.
  - RECOVER: entered the cycle after flush, lasts exactly 1 cycle, then returns to RUN.
  - A flush while in RECOVER restarts RECOVER.
- Offer path (combinational from the free bitmap):
  - Low half (pregs 0..31) has priority over high half (32..63). Lowest set bit wins.
  - alloc_valid = (state==RUN) & ~flush & |free.
- Grant: alloc_req & alloc_valid clears free[alloc_preg] at the clock edge. This is a zero-latency grant: the offer is consumed the same cycle.
- alloc_req with alloc_valid=0 has no effect. Rename must stall; there is no queuing.
- Release: release_valid sets free[release_preg] and clears committed_used[release_preg].
- Commit: commit_valid sets committed_used[commit_preg].
- Same-cycle events:
  - Grant and release in the same cycle are both applied. A released preg is not offered until the next cycle.
  - free_count changes by +1 (release only), -1 (grant only), or 0 (both).
- Flush (sampled at the edge):
  - Next free = ~committed_used_next, where committed_used_next already includes any same-cycle commit and release.
  - Any grant in the flush cycle is suppressed.
  - free_count is recomputed as a popcount and is valid from the RECOVER cycle onward.
- Preg 0 ($zero mapping) is never released by the core. The block does not special-case it.
- Release of an already-free preg, or commit of a preg not in use, is illegal. The bitmap update still applies as specified.

Optional Feature:
- FREE_LIST_CHECK_EN defined:
  - Adds output err_sticky (1 bit, reset 0).
  - err_sticky is set on any of: release of an already-free preg; commit of a free preg; release and commit of the same preg in one cycle; free_count mismatching the popcount of free.
  - It stays set until reset.
  - Also adds simulation assertions for the same conditions.
- FREE_LIST_CHECK_EN undefined: port absent, no checking logic.

Decomposition:
- Shared package mips_core_pkg gets:
  - typedef logic [5:0] preg_t
  - typedef enum {RUN, RECOVER} fl_state_t
  - localparams PREG_W=6 and FL_COUNT_W=7
- Sub-module: reuse priority_encoder_32, two instances (low half, high half) configured for lowest-index selection.
- The top level muxes the two instances on |free[31:0] and prepends the half bit.

Test Plan:
- Reset, then alloc_req held 32 cycles: grants 32,33,...,63 in order. Cycle 33: alloc_valid=0, empty=1, free_count=0.
- After draining, release_valid with release_preg=5: next cycle alloc_valid=1, alloc_preg=5, free_count=1.
- Same cycle: grant of 40 plus release of 7. Result: free_count unchanged, free[40]=0, free[7]=1. Next offer is 7 if it is the lowest free.
- Allocate 32..35, commit 32 and 33, then flush. RECOVER cycle: alloc_valid=0. Following cycle: offer=34, free_count=30 (34,35 and 36..63 free; 32,33 held).
- Flush in the same cycle as commit_preg=34: 34 stays held after recovery. alloc_req in the flush cycle is ignored (no bit cleared).
- FREE_LIST_CHECK_EN: release_preg=50 while 50 is free -> err_sticky=1 next cycle, and it stays 1 until rst_n=0.
